// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates tags at dispatch, captures CDB results and retires in program order.
// Optional ROB_BYPASS_EN: operand lookups also see the same-cycle CDB broadcast.
module reorder_buffer #(
  parameter int ROB_SIZE  = 16,
  parameter int ROB_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [4:0]           issue_rd,
  input  logic                 issue_is_branch,
  input  logic                 issue_pred_taken,
  output logic [ROB_IDX_W-1:0] issue_tag,
  input  logic                 cdb_valid,
  input  logic [ROB_IDX_W-1:0] cdb_tag,
  input  logic [31:0]          cdb_value,
  input  logic                 cdb_taken,
  input  logic [31:0]          cdb_target,
  input  logic [ROB_IDX_W-1:0] q1_tag,
  input  logic [ROB_IDX_W-1:0] q2_tag,
  output logic                 q1_ready,
  output logic                 q2_ready,
  output logic [31:0]          q1_value,
  output logic [31:0]          q2_value,
  output logic                 commit_valid,
  output logic [4:0]           commit_rd,
  output logic [31:0]          commit_value,
  output logic [ROB_IDX_W-1:0] commit_tag,
  output logic                 jump_wrong,
  output logic [31:0]          jump_target
);

  localparam logic [ROB_IDX_W:0] FULL = ROB_SIZE[ROB_IDX_W:0];

  logic                 busy        [ROB_SIZE];
  logic                 entry_ready [ROB_SIZE];
  logic [4:0]           entry_rd    [ROB_SIZE];
  logic [31:0]          entry_value [ROB_SIZE];
  logic                 entry_br    [ROB_SIZE];
  logic                 entry_pred  [ROB_SIZE];
  logic                 entry_taken [ROB_SIZE];
  logic [31:0]          entry_tgt   [ROB_SIZE];

  logic [ROB_IDX_W-1:0] head, tail;
  logic [ROB_IDX_W:0]   count;

  logic head_done, mispredict, commit_fire, issue_fire, cdb_hit;

  assign issue_ready = (count < FULL);
  assign issue_tag   = tail;
  assign cdb_hit     = cdb_valid && busy[cdb_tag];

  always_comb begin
    head_done   = (count != '0) && busy[head] && entry_ready[head];
    mispredict  = head_done && entry_br[head] && (entry_taken[head] != entry_pred[head]);
    commit_fire = rdy && head_done && !mispredict;
    issue_fire  = rdy && issue_valid && issue_ready && !mispredict;
  end

  always_comb begin
    q1_ready = busy[q1_tag] && entry_ready[q1_tag];
    q1_value = entry_value[q1_tag];
    q2_ready = busy[q2_tag] && entry_ready[q2_tag];
    q2_value = entry_value[q2_tag];
`ifdef ROB_BYPASS_EN
    if (cdb_valid && cdb_tag == q1_tag) begin
      q1_ready = 1'b1;
      q1_value = cdb_value;
    end
    if (cdb_valid && cdb_tag == q2_tag) begin
      q2_ready = 1'b1;
      q2_value = cdb_value;
    end
`endif
  end

  // Control state: pointers, occupancy and busy/ready flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy         <= '{default: 1'b0};
      entry_ready  <= '{default: 1'b0};
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      commit_valid <= 1'b0;
      commit_rd    <= '0;
      commit_value <= '0;
      commit_tag   <= '0;
      jump_wrong   <= 1'b0;
      jump_target  <= '0;
    end else begin
      commit_valid <= 1'b0;
      jump_wrong   <= 1'b0;
      if (rdy) begin
        if (mispredict) begin
          busy        <= '{default: 1'b0};
          entry_ready <= '{default: 1'b0};
          head        <= '0;
          tail        <= '0;
          count       <= '0;
          jump_wrong  <= 1'b1;
          jump_target <= entry_tgt[head];
        end else begin
          if (cdb_hit)
            entry_ready[cdb_tag] <= 1'b1;
          if (issue_fire) begin
            busy[tail]        <= 1'b1;
            entry_ready[tail] <= 1'b0;
            tail              <= tail + 1'b1;
          end
          // Issue never targets head while commit fires: that needs a full buffer.
          if (commit_fire) begin
            busy[head]        <= 1'b0;
            entry_ready[head] <= 1'b0;
            head              <= head + 1'b1;
            commit_valid      <= 1'b1;
            commit_rd         <= entry_br[head] ? 5'd0 : entry_rd[head];
            commit_value      <= entry_value[head];
            commit_tag        <= head;
          end
          if (issue_fire && !commit_fire)
            count <= count + 1'b1;
          else if (!issue_fire && commit_fire)
            count <= count - 1'b1;
        end
      end
    end
  end

  // Payload storage; validity is tracked entirely by busy/ready.
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (issue_fire) begin
        entry_rd[tail]   <= issue_rd;
        entry_br[tail]   <= issue_is_branch;
        entry_pred[tail] <= issue_pred_taken;
      end
      if (cdb_hit) begin
        entry_value[cdb_tag] <= cdb_value;
        entry_taken[cdb_tag] <= cdb_taken;
        entry_tgt[cdb_tag]   <= cdb_target;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer (honours ROB_BYPASS_EN like the design).
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [4:0]  issue_rd = '0;
  logic        issue_is_branch = 1'b0;
  logic        issue_pred_taken = 1'b0;
  logic [3:0]  issue_tag;
  logic        cdb_valid = 1'b0;
  logic [3:0]  cdb_tag = '0;
  logic [31:0] cdb_value = '0;
  logic        cdb_taken = 1'b0;
  logic [31:0] cdb_target = '0;
  logic [3:0]  q1_tag = '0, q2_tag = '0;
  logic        q1_ready, q2_ready;
  logic [31:0] q1_value, q2_value;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value;
  logic [3:0]  commit_tag;
  logic        jump_wrong;
  logic [31:0] jump_target;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  reorder_buffer #(.ROB_SIZE(16), .ROB_IDX_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rd(issue_rd),
    .issue_is_branch(issue_is_branch), .issue_pred_taken(issue_pred_taken), .issue_tag(issue_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cdb_taken(cdb_taken), .cdb_target(cdb_target),
    .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_value(q1_value), .q2_value(q2_value),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
    .commit_tag(commit_tag), .jump_wrong(jump_wrong), .jump_target(jump_target)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_rd = '0; issue_is_branch = 1'b0; issue_pred_taken = 1'b0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0; cdb_taken = 1'b0; cdb_target = '0;
    q1_tag = '0; q2_tag = '0; rdy = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic issue(input logic [4:0] rd, input logic br, input logic pred);
    issue_valid = 1'b1; issue_rd = rd; issue_is_branch = br; issue_pred_taken = pred;
    step();
    issue_valid = 1'b0; issue_is_branch = 1'b0; issue_pred_taken = 1'b0;
  endtask

  task automatic cdb(input logic [3:0] t, input logic [31:0] v, input logic tk, input logic [31:0] tg);
    cdb_valid = 1'b1; cdb_tag = t; cdb_value = v; cdb_taken = tk; cdb_target = tg;
    step();
    cdb_valid = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    #3;
    check("rst_commit_valid", 32'(commit_valid), 32'd0);
    check("rst_jump_wrong",   32'(jump_wrong),   32'd0);
    check("rst_jump_target",  jump_target,       32'd0);
    check("rst_commit_rd",    32'(commit_rd),    32'd0);
    check("rst_commit_tag",   32'(commit_tag),   32'd0);
    check("rst_issue_ready",  32'(issue_ready),  32'd1);
    check("rst_issue_tag",    32'(issue_tag),    32'd0);
    #10;
    rst = 1'b1;
    step();

    // Single issue, CDB, commit
    issue_valid = 1'b1; issue_rd = 5'd5;
    #1;
    check("t1_issue_tag", 32'(issue_tag), 32'd0);
    step();
    issue_valid = 1'b0;
    cdb(4'd0, 32'h1234, 1'b0, 32'h0);
    check("t1_no_early_commit", 32'(commit_valid), 32'd0);
    step();
    check("t1_commit_valid", 32'(commit_valid), 32'd1);
    check("t1_commit_rd",    32'(commit_rd),    32'd5);
    check("t1_commit_value", commit_value,      32'h1234);
    check("t1_commit_tag",   32'(commit_tag),   32'd0);
    step();
    check("t1_pulse_ends", 32'(commit_valid), 32'd0);

    // Fill all 16 entries, then a 17th issue must be dropped
    do_reset();
    for (int i = 0; i < 16; i++) begin
      issue_valid = 1'b1; issue_rd = 5'(i + 1);
      #1;
      check("t2_issue_tag", 32'(issue_tag), 32'(i));
      step();
    end
    issue_rd = 5'd30;
    #1;
    check("t2_full_not_ready", 32'(issue_ready), 32'd0);
    check("t2_full_tag",       32'(issue_tag),   32'd0);
    step();
    check("t2_tail_stays", 32'(issue_tag), 32'd0);
    issue_valid = 1'b0;
    cdb(4'd0, 32'hA0, 1'b0, 32'h0);
    step();
    check("t2_commit_valid", 32'(commit_valid), 32'd1);
    check("t2_entry0_rd",    32'(commit_rd),    32'd1);
    check("t2_commit_tag",   32'(commit_tag),   32'd0);

    // Out-of-order completion, in-order retirement
    do_reset();
    issue(5'd1, 1'b0, 1'b0);
    issue(5'd2, 1'b0, 1'b0);
    cdb(4'd1, 32'h22, 1'b0, 32'h0);
    check("t3_no_commit_young", 32'(commit_valid), 32'd0);
    cdb(4'd0, 32'h11, 1'b0, 32'h0);
    check("t3_no_commit_yet", 32'(commit_valid), 32'd0);
    step();
    check("t3_c0_valid", 32'(commit_valid), 32'd1);
    check("t3_c0_tag",   32'(commit_tag),   32'd0);
    check("t3_c0_value", commit_value,      32'h11);
    check("t3_c0_rd",    32'(commit_rd),    32'd1);
    step();
    check("t3_c1_valid", 32'(commit_valid), 32'd1);
    check("t3_c1_tag",   32'(commit_tag),   32'd1);
    check("t3_c1_value", commit_value,      32'h22);
    step();
    check("t3_idle", 32'(commit_valid), 32'd0);

    // Correctly predicted branch commits with rd forced to 0
    do_reset();
    issue(5'd9, 1'b1, 1'b1);
    cdb(4'd0, 32'h5, 1'b1, 32'h40);
    step();
    check("t4_br_ok_valid", 32'(commit_valid), 32'd1);
    check("t4_br_ok_rd",    32'(commit_rd),    32'd0);
    check("t4_br_ok_nojw",  32'(jump_wrong),   32'd0);

    // Mispredicted branch flushes everything
    do_reset();
    issue(5'd7, 1'b1, 1'b0);
    issue(5'd3, 1'b0, 1'b0);
    cdb(4'd0, 32'h0, 1'b1, 32'h80);
    issue_valid = 1'b1; issue_rd = 5'd12;
    step();
    issue_valid = 1'b0;
    check("t5_jump_wrong",   32'(jump_wrong),   32'd1);
    check("t5_jump_target",  jump_target,       32'h80);
    check("t5_no_commit",    32'(commit_valid), 32'd0);
    check("t5_tag_restart",  32'(issue_tag),    32'd0);
    check("t5_ready_after",  32'(issue_ready),  32'd1);
    cdb(4'd1, 32'h99, 1'b0, 32'h0);
    check("t5_jw_pulse_ends", 32'(jump_wrong), 32'd0);
    q1_tag = 4'd1;
    #1;
    check("t5_flushed_entry", 32'(q1_ready), 32'd0);
    q1_tag = 4'd0;
    #1;
    check("t5_same_cycle_issue_gone", 32'(q1_ready), 32'd0);
    step();
    check("t5_no_stray_commit", 32'(commit_valid), 32'd0);

    // Operand lookup and CDB bypass
    do_reset();
    for (int i = 0; i < 4; i++) issue(5'(i + 1), 1'b0, 1'b0);
    q1_tag = 4'd3; q2_tag = 4'd3;
    cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_value = 32'hAB;
    #1;
`ifdef ROB_BYPASS_EN
    check("t6_q1_ready_same", 32'(q1_ready), 32'd1);
    check("t6_q1_value_same", q1_value,      32'hAB);
    check("t6_q2_ready_same", 32'(q2_ready), 32'd1);
`else
    check("t6_q1_ready_same", 32'(q1_ready), 32'd0);
    check("t6_q2_ready_same", 32'(q2_ready), 32'd0);
`endif
    step();
    cdb_valid = 1'b0;
    #1;
    check("t6_q1_ready_next", 32'(q1_ready), 32'd1);
    check("t6_q1_value_next", q1_value,      32'hAB);
    check("t6_q2_value_next", q2_value,      32'hAB);
    q2_tag = 4'd2;
    #1;
    check("t6_q2_not_ready", 32'(q2_ready), 32'd0);

    // rdy=0 freezes everything
    do_reset();
    issue(5'd4, 1'b0, 1'b0);
    cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_value = 32'h55;
    step();
    cdb_valid = 1'b0;
    rdy = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd6;
    step();
    check("t7_frozen_no_commit", 32'(commit_valid), 32'd0);
    step();
    check("t7_frozen_no_commit2", 32'(commit_valid), 32'd0);
    check("t7_frozen_tail",       32'(issue_tag),    32'd1);
    issue_valid = 1'b0;
    rdy = 1'b1;
    step();
    check("t7_commit_valid", 32'(commit_valid), 32'd1);
    check("t7_commit_tag",   32'(commit_tag),   32'd0);
    check("t7_commit_value", commit_value,      32'h55);
    check("t7_commit_rd",    32'(commit_rd),    32'd4);

    // Simultaneous issue and commit: both pointers move, occupancy unchanged
    do_reset();
    issue(5'd8, 1'b0, 1'b0);
    cdb(4'd0, 32'h77, 1'b0, 32'h0);
    issue_valid = 1'b1; issue_rd = 5'd10;
    step();
    issue_valid = 1'b0;
    check("t8_commit_valid", 32'(commit_valid), 32'd1);
    check("t8_commit_tag",   32'(commit_tag),   32'd0);
    check("t8_tail",         32'(issue_tag),    32'd2);
    cdb(4'd1, 32'h88, 1'b0, 32'h0);
    step();
    check("t8_second_commit", 32'(commit_valid), 32'd1);
    check("t8_second_tag",    32'(commit_tag),   32'd1);
    check("t8_second_rd",     32'(commit_rd),    32'd10);
    step();
    check("t8_empty_no_commit", 32'(commit_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

endmodule
